// File: rtl/writeback_arbiter.sv
// Writeback arbiter: ALU/MUL/cache results share the single RoB writeback port through
// one-entry per-source buffers, a round-robin picker and a registered output stage.
module writeback_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ROB_TAG_W = 3,
    parameter int XCPT_W    = 68
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic [2:0]             req_valid,
    output logic [2:0]             req_ready,
    input  logic [3*ROB_TAG_W-1:0] req_tag,
    input  logic [3*DATA_W-1:0]    req_data,
    input  logic [3*XCPT_W-1:0]    req_xcpt,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [ROB_TAG_W-1:0]   wb_tag,
    output logic [DATA_W-1:0]      wb_data,
    output logic [XCPT_W-1:0]      wb_xcpt,
    output logic [1:0]             wb_src
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // A producer holds valid and payload stable until it transfers; ready may depend on valid.

    logic [2:0]           buf_full;
    logic [ROB_TAG_W-1:0] buf_tag  [3];
    logic [DATA_W-1:0]    buf_data [3];
    logic [XCPT_W-1:0]    buf_xcpt [3];
    logic [1:0]           rr_ptr;

    logic [1:0] cand0, cand1, cand2;
    logic [1:0] win;
    logic       any_full;
    logic [2:0] grant;
    logic       out_load;
    logic [2:0] accept;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign out_load = ~wb_valid | wb_ready;

    assign cand0 = rr_ptr;
    assign cand1 = inc3(rr_ptr);
    assign cand2 = inc3(cand1);

    // Walk from the lowest priority candidate up so the highest-priority full buffer wins.
    always_comb begin
        win      = 2'd0;
        any_full = 1'b0;
        if (buf_full[cand2]) begin
            win      = cand2;
            any_full = 1'b1;
        end
        if (buf_full[cand1]) begin
            win      = cand1;
            any_full = 1'b1;
        end
        if (buf_full[cand0]) begin
            win      = cand0;
            any_full = 1'b1;
        end
    end

    // No grant while the output stage is stalled.
    assign grant     = (any_full & out_load) ? (3'b001 << win) : 3'b000;
    assign req_ready = {3{~flush}} & (~buf_full | grant);
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_full <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                buf_tag[i]  <= '0;
                buf_data[i] <= '0;
                buf_xcpt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (flush) begin
                    buf_full[i] <= 1'b0;
                end else if (accept[i]) begin
                    buf_full[i] <= 1'b1;
                    buf_tag[i]  <= req_tag[i*ROB_TAG_W +: ROB_TAG_W];
                    buf_data[i] <= req_data[i*DATA_W +: DATA_W];
                    buf_xcpt[i] <= req_xcpt[i*XCPT_W +: XCPT_W];
                end else if (grant[i]) begin
                    buf_full[i] <= 1'b0;
                end
            end
        end
    end

    // Data outputs only change on a load, so a flush or an idle load leaves them holding.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_tag   <= '0;
            wb_data  <= '0;
            wb_xcpt  <= '0;
            wb_src   <= 2'd0;
            rr_ptr   <= 2'd0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (out_load) begin
            if (any_full) begin
                wb_valid <= 1'b1;
                wb_tag   <= buf_tag[win];
                wb_data  <= buf_data[win];
                wb_xcpt  <= buf_xcpt[win];
                wb_src   <= win;
                rr_ptr   <= inc3(win);
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

    a_wb_stable: assert property (@(posedge clock) disable iff (!reset_n)
        (wb_valid && !wb_ready && !flush) |=>
            (wb_valid && $stable(wb_tag) && $stable(wb_data) && $stable(wb_xcpt) && $stable(wb_src)));

    a_grant_onehot0: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(grant));

    a_no_accept_on_flush: assert property (@(posedge clock) disable iff (!reset_n)
        flush |-> (accept == 3'b000));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a queue/arithmetic model of the arbiter's rules.
module tb_writeback_arbiter;

    localparam int DW = 32;
    localparam int TW = 3;
    localparam int XW = 68;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           flush = 1'b0;
    logic [2:0]     req_valid = '0;
    logic [2:0]     req_ready;
    logic [3*TW-1:0] req_tag = '0;
    logic [3*DW-1:0] req_data = '0;
    logic [3*XW-1:0] req_xcpt = '0;
    logic           wb_valid;
    logic           wb_ready = 1'b0;
    logic [TW-1:0]  wb_tag;
    logic [DW-1:0]  wb_data;
    logic [XW-1:0]  wb_xcpt;
    logic [1:0]     wb_src;

    writeback_arbiter #(.DATA_W(DW), .ROB_TAG_W(TW), .XCPT_W(XW)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_tag  (req_tag),
        .req_data (req_data),
        .req_xcpt (req_xcpt),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_tag   (wb_tag),
        .wb_data  (wb_data),
        .wb_xcpt  (wb_xcpt),
        .wb_src   (wb_src)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each source holds at most one pending request; the RoB port is one register.
    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic [XW-1:0] xcpt;
    } req_t;

    req_t       m_pend [3][$];
    int         m_ptr;
    bit         m_wbv;
    req_t       m_out;
    int         m_src;
    logic [2:0] m_ready;
    int         m_win;
    bit         m_load;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pend[i].delete();
        m_ptr = 0;
        m_wbv = 0;
        m_out = '0;
        m_src = 0;
    endtask

    task automatic model_eval();
        m_load = !m_wbv || wb_ready;
        m_win  = -1;
        if (m_load) begin
            for (int k = 0; k < 3; k++) begin
                int s;
                s = (m_ptr + k) % 3;
                if (m_win < 0 && m_pend[s].size() != 0) m_win = s;
            end
        end
        for (int i = 0; i < 3; i++)
            m_ready[i] = !flush && (m_pend[i].size() == 0 || m_win == i);
    endtask

    task automatic model_update();
        if (flush) begin
            for (int i = 0; i < 3; i++) m_pend[i].delete();
            m_wbv = 0;
            return;
        end
        if (m_load) begin
            if (m_win >= 0) begin
                m_out = m_pend[m_win].pop_front();
                m_src = m_win;
                m_wbv = 1;
                m_ptr = (m_win + 1) % 3;
            end else begin
                m_wbv = 0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (req_valid[i] && m_ready[i]) begin
                req_t r;
                r.tag  = req_tag[i*TW +: TW];
                r.data = req_data[i*DW +: DW];
                r.xcpt = req_xcpt[i*XW +: XW];
                m_pend[i].push_back(r);
            end
        end
    endtask

    task automatic check_outputs();
        check("wb_valid", wb_valid, m_wbv);
        check("wb_tag",   wb_tag,   m_out.tag);
        check("wb_data",  wb_data,  m_out.data);
        check("wb_xcpt",  wb_xcpt,  m_out.xcpt);
        check("wb_src",   wb_src,   m_src[1:0]);
    endtask

    // One clock: check combinational ready, take the edge, check registered outputs.
    task automatic step();
        #1;
        model_eval();
        check("req_ready", req_ready, m_ready);
        @(posedge clock);
        model_update();
        #1;
        check_outputs();
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d,
                           input logic [XW-1:0] x);
        req_tag[i*TW +: TW]  = t;
        req_data[i*DW +: DW] = d;
        req_xcpt[i*XW +: XW] = x;
    endtask

    task automatic rand_reqs(input logic [2:0] v);
        req_valid = v;
        for (int i = 0; i < 3; i++)
            set_req(i, TW'($urandom), $urandom, {4'($urandom), $urandom, $urandom});
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        wb_ready  = 1'b0;
        #2;
        model_reset();
        check_outputs();
        check("rst_ready", req_ready, 3'b111);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // ---------------- scoreboard for the round-robin sequence ----------------
    logic [1:0] exp_q[$];

    logic [XW-1:0] xc;

    initial begin
        // 1. reset / idle
        do_reset();
        wb_ready = 1'b1;
        step();
        check("idle_valid", wb_valid, 1'b0);

        // 2. single ALU request, visible two edges after acceptance
        req_valid = 3'b001;
        set_req(0, 3'd5, 32'hDEAD_BEEF, '0);
        step();
        check("lat_t1_valid", wb_valid, 1'b0);
        req_valid = 3'b000;
        step();
        check("lat_valid", wb_valid, 1'b1);
        check("lat_tag",   wb_tag, 3'd5);
        check("lat_data",  wb_data, 32'hDEAD_BEEF);
        check("lat_src",   wb_src, 2'd0);
        step();

        // 3. three saturated sources from rr_ptr=0
        do_reset();
        wb_ready = 1'b1;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        for (int c = 0; c < 8; c++) begin
            rand_reqs(3'b111);
            step();
            if (wb_valid && exp_q.size() != 0) check("rr_src", wb_src, exp_q.pop_front());
        end
        check("rr_drained", exp_q.size(), 0);
        req_valid = '0;
        repeat (4) step();

        // 4. backpressure with MUL in the output and cache buffered
        do_reset();
        wb_ready  = 1'b1;
        req_valid = 3'b110;
        set_req(1, 3'd3, 32'h1111_0003, '0);
        set_req(2, 3'd6, 32'h2222_0006, '0);
        step();
        req_valid = 3'b000;
        wb_ready  = 1'b0;
        step();
        check("bp_load_src", wb_src, 2'd1);
        for (int c = 0; c < 4; c++) begin
            rand_reqs(3'b100);
            #1;
            check("bp_ready2", req_ready[2], 1'b0);
            step();
            check("bp_hold_valid", wb_valid, 1'b1);
            check("bp_hold_tag", wb_tag, 3'd3);
            check("bp_hold_src", wb_src, 2'd1);
        end
        req_valid = 3'b000;
        wb_ready  = 1'b1;
        step();
        check("bp_next_src", wb_src, 2'd2);
        check("bp_next_tag", wb_tag, 3'd6);
        check("bp_next_data", wb_data, 32'h2222_0006);
        step();

        // 5. flush with everything full and the output stalled
        do_reset();
        wb_ready = 1'b0;
        rand_reqs(3'b111);
        step();
        rand_reqs(3'b111);
        step();
        check("fl_pre_valid", wb_valid, 1'b1);
        rand_reqs(3'b111);
        flush = 1'b1;
        #1;
        check("fl_ready", req_ready, 3'b000);
        step();
        check("fl_valid", wb_valid, 1'b0);
        flush     = 1'b0;
        req_valid = 3'b000;
        wb_ready  = 1'b1;
        #1;
        check("fl_empty_ready", req_ready, 3'b111);
        step();
        check("fl_no_accept", wb_valid, 1'b0);
        rand_reqs(3'b111);
        step();
        req_valid = 3'b000;
        step();
        check("fl_ptr_src", wb_src, 2'd1);
        repeat (4) step();

        // 6. cache request carrying an exception: {valid, cause=dTlb_miss, pc}
        xc = {1'b1, 3'd2, 64'h0000_0000_0000_2000};
        req_valid = 3'b100;
        set_req(2, 3'd4, 32'hCAFE_0004, xc);
        step();
        req_valid = 3'b000;
        step();
        check("xc_valid", wb_valid, 1'b1);
        check("xc_bits",  wb_xcpt, xc);
        check("xc_src",   wb_src, 2'd2);
        step();

        // randomized traffic with occasional flushes and one asynchronous reset
        for (int c = 0; c < 1500; c++) begin
            rand_reqs(3'($urandom));
            wb_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 31) == 0);
            step();
            if (c == 700) begin
                do_reset();
                wb_ready = 1'b1;
            end
        end
        flush     = 1'b0;
        req_valid = '0;
        wb_ready  = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
